cpu_sequencer: RTL and testbench

- Multi-cycle sequencer for the cpu core.
- Steps each instruction through fetch, decode, execute, memory and writeback around the existing combinational instruction decoder and ALU.
- Owns the PC, the instruction register and a single shared memory port used for both instruction fetch and SW data stores.
- Gates the decoder's write enables so each write occurs exactly once per instruction.

---
 rtl/cpu_seq_pkg.sv | 20 ++
 rtl/cpu_sequencer_if.sv | 20 ++
 rtl/cpu_pc_unit.sv | 38 +++
 rtl/cpu_sequencer.sv | 136 +++++++++++++
 tb/tb_cpu_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared constants for the multi-cycle cpu sequencer: FSM encoding, reset PC
// and the base opcodes used when building instruction words.
package cpu_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared instruction/data memory port; the sequencer is the master.
interface cpu_sequencer_if #(
  parameter int PC_W = 32
);
  logic            mem_req;
  logic            mem_is_data;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     instr_in;

  modport master (
    output mem_req, mem_is_data, mem_addr,
    input  mem_ack, instr_in
  );

  modport slave (
    input  mem_req, mem_is_data, mem_addr,
    output mem_ack, instr_in
  );
endinterface

// File: rtl/cpu_pc_unit.sv
// Program counter with hold / +4 / branch-target next-PC selection.
module cpu_pc_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            take_branch,
  input  logic [11:0]     imm12,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] offset;

  // Word offset sign-extended to byte offset; sums wrap modulo 2^PC_W.
  assign offset = {{(PC_W-14){imm12[11]}}, imm12, 2'b00};

  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      pc_d = take_branch ? (pc_q + offset) : (pc_q + PC_W'(4));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer around the
// combinational decoder and ALU; owns PC, IR and the shared memory port.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  cpu_sequencer_if.master       mem,
  output logic [31:0]           ir,
  input  logic                  dec_rf_we,
  input  logic                  dec_mem_we,
  input  logic                  dec_branch,
  input  logic [11:0]           dec_imm12,
  input  logic [31:0]           alu_result,
  input  logic                  alu_nonzero,
  output logic                  rf_we,
  output logic                  mem_we,
  output logic [PC_W-1:0]       pc,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [31:0]           retired
);

  logic [2:0]      state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [31:0]     retired_q, retired_d;
  logic            advance;
  logic            take_branch;
  logic [2:0]      boundary_state;

  cpu_pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    .take_branch (take_branch),
    .imm12       (dec_imm12),
    .pc          (pc)
  );

  // Where to go once an instruction retires: stop cleanly if run dropped.
  assign boundary_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    addr_d          = addr_q;
    retired_d       = retired_q;
    advance         = 1'b0;
    take_branch     = 1'b0;
    mem.mem_req     = 1'b0;
    mem.mem_is_data = 1'b0;
    mem.mem_addr    = pc;
    rf_we           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_d    = mem.instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_rf_we && !dec_mem_we && !dec_branch) state_d = S_HALT;
        else                                           state_d = S_EXEC;
      end
      S_EXEC: begin
        addr_d = alu_result[PC_W-1:0];
        if (dec_mem_we) begin
          state_d = S_MEM;
        end else if (dec_rf_we) begin
          state_d = S_WB;
        end else begin
          advance     = 1'b1;
          take_branch = alu_nonzero;
          retired_d   = retired_q + 32'd1;
          state_d     = boundary_state;
        end
      end
      S_MEM: begin
        mem.mem_req     = 1'b1;
        mem.mem_is_data = 1'b1;
        mem.mem_addr    = addr_q;
        if (mem.mem_ack) begin
          advance   = 1'b1;
          retired_d = retired_q + 32'd1;
          state_d   = boundary_state;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        advance   = 1'b1;
        retired_d = retired_q + 32'd1;
        state_d   = boundary_state;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= 32'd0;
      addr_q    <= '0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      addr_q    <= addr_d;
      retired_q <= retired_d;
    end
  end

  assign mem_we  = mem.mem_req & mem.mem_is_data;
  assign ir      = ir_q;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; the bench plays memory and decoder.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] ir;
  logic        dec_rf_we, dec_mem_we, dec_branch;
  logic [11:0] dec_imm12;
  logic [31:0] alu_result;
  logic        alu_nonzero;
  logic        rf_we, mem_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int rf_pulses = 0;
  logic [31:0] exp_ret;

  cpu_sequencer_if #(.PC_W(32)) bus ();

  cpu_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem         (bus),
    .ir          (ir),
    .dec_rf_we   (dec_rf_we),
    .dec_mem_we  (dec_mem_we),
    .dec_branch  (dec_branch),
    .dec_imm12   (dec_imm12),
    .alu_result  (alu_result),
    .alu_nonzero (alu_nonzero),
    .rf_we       (rf_we),
    .mem_we      (mem_we),
    .pc          (pc),
    .state       (state),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) rf_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic rfw, input logic mw, input logic br);
    dec_rf_we  = rfw;
    dec_mem_we = mw;
    dec_branch = br;
  endtask

  // Expects FETCH on entry; zero-wait fetch of a BNE, then checks the new PC.
  task automatic do_branch(input logic [11:0] imm, input logic nz, input logic [31:0] exp_pc);
    bus.instr_in = {20'h00001, 5'd0, OP_BRANCH};
    set_dec(1'b0, 1'b0, 1'b1);
    dec_imm12   = imm;
    alu_nonzero = nz;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("bne_decode", {29'd0, state}, {29'd0, S_DECODE});
    tick();
    chk("bne_exec", {29'd0, state}, {29'd0, S_EXEC});
    tick();
    exp_ret = exp_ret + 32'd1;
    chk("bne_state", {29'd0, state}, {29'd0, S_FETCH});
    chk("bne_pc", pc, exp_pc);
    chk("bne_retired", retired, exp_ret);
    $display("txn BNE imm=%h nz=%0d pc=%h retired=%0d", imm, nz, pc, retired);
  endtask

  // Expects FETCH on entry; zero-wait ADDI through WB.
  task automatic do_alu(input logic [31:0] exp_pc);
    bus.instr_in = {12'h001, 5'd0, 3'b000, 5'd1, OP_IMM};
    set_dec(1'b1, 1'b0, 1'b0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    tick();
    chk("alu_wb_rfwe", {31'd0, rf_we}, 32'd1);
    tick();
    exp_ret = exp_ret + 32'd1;
    chk("alu_pc", pc, exp_pc);
    chk("alu_retired", retired, exp_ret);
    $display("txn ADDI pc=%h retired=%0d", pc, retired);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0;
    bus.mem_ack = 1'b0; bus.instr_in = 32'd0;
    set_dec(1'b0, 1'b0, 1'b0);
    dec_imm12 = 12'd0; alu_result = 32'd0; alu_nonzero = 1'b0;
    exp_ret = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_strobes", {29'd0, bus.mem_req, mem_we, rf_we}, 32'd0);

    // ADDI with two wait cycles before the ack
    bus.instr_in = 32'h0010_0093;
    set_dec(1'b1, 1'b0, 1'b0);
    run = 1'b1;
    tick();
    chk("addi_fetch_state", {29'd0, state}, {29'd0, S_FETCH});
    chk("addi_fetch_req", {30'd0, bus.mem_req, bus.mem_is_data}, 32'd2);
    chk("addi_fetch_addr", bus.mem_addr, 32'd0);
    tick();
    chk("addi_wait1_state", {29'd0, state}, {29'd0, S_FETCH});
    tick();
    chk("addi_wait2_ir", ir, 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("addi_ir", ir, 32'h0010_0093);
    chk("addi_decode", {29'd0, state}, {29'd0, S_DECODE});
    chk("addi_decode_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("addi_exec", {29'd0, state}, {29'd0, S_EXEC});
    tick();
    chk("addi_wb", {29'd0, state}, {29'd0, S_WB});
    chk("addi_rfwe", {31'd0, rf_we}, 32'd1);
    tick();
    exp_ret = 32'd1;
    chk("addi_rfwe_off", {31'd0, rf_we}, 32'd0);
    chk("addi_pc", pc, 32'd4);
    chk("addi_retired", retired, exp_ret);
    chk("addi_rf_pulses", rf_pulses, 32'd1);
    $display("txn ADDI pc=%h retired=%0d", pc, retired);

    // SW, store address 0x40 latched in EXEC
    chk("sw_fetch_addr", bus.mem_addr, 32'd4);
    bus.instr_in = 32'h0020_A023;
    set_dec(1'b0, 1'b1, 1'b0);
    alu_result = 32'h40;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    tick();
    chk("sw_mem_state", {29'd0, state}, {29'd0, S_MEM});
    chk("sw_mem_strobes", {29'd0, bus.mem_req, bus.mem_is_data, mem_we}, 32'd7);
    chk("sw_mem_addr", bus.mem_addr, 32'h40);
    alu_result = 32'h99;
    tick();
    chk("sw_addr_held", bus.mem_addr, 32'h40);
    chk("sw_req_held", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    exp_ret = 32'd2;
    chk("sw_pc", pc, 32'd8);
    chk("sw_retired", retired, exp_ret);
    chk("sw_no_rfwe", rf_pulses, 32'd1);
    chk("sw_next_fetch", {29'd0, state}, {29'd0, S_FETCH});
    $display("txn SW addr=40 pc=%h retired=%0d", pc, retired);

    // Branches: forward to 0x10, then BNE -2 taken / not taken
    do_branch(12'h002, 1'b1, 32'h10);
    do_branch(12'hFFE, 1'b1, 32'h08);
    do_branch(12'h002, 1'b1, 32'h10);
    do_branch(12'hFFE, 1'b0, 32'h14);

    // run dropped during MEM: store finishes, then IDLE
    bus.instr_in = 32'h0020_A023;
    set_dec(1'b0, 1'b1, 1'b0);
    alu_result = 32'h80;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("stop_mem_state", {29'd0, state}, {29'd0, S_MEM});
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    exp_ret = exp_ret + 32'd1;
    chk("stop_idle", {29'd0, state}, {29'd0, S_IDLE});
    chk("stop_pc", pc, 32'h18);
    chk("stop_retired", retired, exp_ret);
    tick();
    chk("stop_no_req", {31'd0, bus.mem_req}, 32'd0);
    run = 1'b1;
    tick();
    chk("resume_state", {29'd0, state}, {29'd0, S_FETCH});
    chk("resume_addr", bus.mem_addr, 32'h18);
    $display("txn SW-stop pc=%h retired=%0d", pc, retired);

    // Illegal all-zero word -> HALT
    bus.instr_in = 32'd0;
    set_dec(1'b0, 1'b0, 1'b0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("halt_state", {29'd0, state}, {29'd0, S_HALT});
    chk("halt_flag", {31'd0, halted}, 32'd1);
    tick(); tick(); tick();
    chk("halt_sticky", {29'd0, state}, {29'd0, S_HALT});
    chk("halt_no_req", {31'd0, bus.mem_req}, 32'd0);
    chk("halt_retired", retired, exp_ret);
    rst_n = 1'b0;
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_ret = 32'd0;
    chk("unhalt_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("unhalt_pc", pc, 32'd0);
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    $display("txn ILLEGAL halted then reset pc=%h", pc);

    // Reset while a fetch awaits its ack; a late ack is ignored
    run = 1'b1;
    tick();
    chk("rfetch_req", {31'd0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run = 1'b0;
    chk("rfetch_req_low", {31'd0, bus.mem_req}, 32'd0);
    bus.instr_in = 32'hDEAD_BEEF;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("rfetch_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("rfetch_ir", ir, 32'd0);
    chk("rfetch_retired", retired, 32'd0);
    $display("txn RESET-in-FETCH ir=%h retired=%0d", ir, retired);

    // PC wrap: branch -1 word from 0, then ADDI wraps back to 0
    run = 1'b1;
    tick();
    do_branch(12'hFFF, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    do_alu(32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
